// File: rtl/multiplier_4bits_seq_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier:
// FSM state encodings, operand width and step count.
package multiplier_4bits_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int MUL_W     = 4;
  localparam int MUL_STEPS = 4;

endpackage

// File: rtl/multiplier_4bits_seq_adder.sv
// 4-bit ripple-carry adder built from a chain of one-bit full adders;
// this is the datapath adder used by the sequential multiplier.
module full_adder_4bits (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] carry;

  assign carry[0] = cin;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_bit
      assign sum[gi]      = a[gi] ^ b[gi] ^ carry[gi];
      assign carry[gi+1]  = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
    end
  endgenerate

  assign cout = carry[4];

endmodule

// File: rtl/multiplier_4bits_seq.sv
// Unsigned 4x4 shift-and-add multiplier: four add/shift steps around a
// ripple adder, one product every five cycles when started back-to-back.
module multiplier_4bits_seq
  import multiplier_4bits_seq_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [MUL_W-1:0] a,
  input  logic [MUL_W-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [7:0]       product
);

  state_t           state;
  state_t           state_next;
  logic [MUL_W-1:0] m;
  logic [MUL_W-1:0] acc;
  logic [MUL_W-1:0] q;
  logic [1:0]       step;
  logic [MUL_W-1:0] sum;
  logic             c;
  logic [7:0]       shifted;
  logic             accept;
  logic             last_step;

  full_adder_4bits u_adder (
    .a    (acc),
    .b    (m),
    .cin  (1'b0),
    .sum  (sum),
    .cout (c)
  );

  // The adder carry becomes the top bit of the shifted partial product.
  assign shifted   = q[0] ? {c, sum, q[3:1]} : {1'b0, acc, q[3:1]};
  assign accept    = start && (state != ST_RUN);
  assign last_step = (step == 2'(MUL_STEPS - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_next = ST_RUN;
      end
      ST_RUN: begin
        busy = 1'b1;
        if (last_step) state_next = ST_DONE;
      end
      ST_DONE: begin
        done       = 1'b1;
        state_next = start ? ST_RUN : ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m       <= '0;
      acc     <= '0;
      q       <= '0;
      step    <= '0;
      product <= '0;
    end else if (accept) begin
      m    <= a;
      q    <= b;
      acc  <= '0;
      step <= '0;
    end else if (state == ST_RUN) begin
      acc  <= shifted[7:4];
      q    <= shifted[3:0];
      step <= step + 2'd1;
      if (last_step) product <= shifted;
    end
  end

endmodule

// File: tb/tb_multiplier_4bits_seq.sv
// Directed and table-driven checks of the sequential multiplier:
// latency, carry path, start-while-busy, back-to-back, reset abort, sweep.
module tb_multiplier_4bits_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       busy;
  logic       done;
  logic [7:0] product;

  int checks = 0;
  int errors = 0;
  logic [7:0] last_prod;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] p;
  } vec_t;

  vec_t vecs[8];

  multiplier_4bits_seq dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end
  endtask

  // One full transaction with exact cycle-by-cycle expectations.
  task automatic do_mul(input logic [3:0] va, input logic [3:0] vb,
                        input logic [7:0] exp, input string name);
    a = va; b = vb; start = 1'b1;
    tick();
    start = 1'b0;
    a = ~va; b = ~vb;
    for (int i = 1; i <= 4; i++) begin
      check({name, " busy"}, {7'd0, busy}, 8'd1);
      check({name, " no done"}, {7'd0, done}, 8'd0);
      check({name, " hold"}, product, last_prod);
      tick();
    end
    check({name, " done"}, {7'd0, done}, 8'd1);
    check({name, " idle busy"}, {7'd0, busy}, 8'd0);
    check({name, " product"}, product, exp);
    $display("mul %0d x %0d -> %0d (expected %0d)", va, vb, product, exp);
    last_prod = exp;
    tick();
    check({name, " done pulse"}, {7'd0, done}, 8'd0);
  endtask

  initial begin
    vecs[0] = '{4'd3,  4'd5,  8'd15};
    vecs[1] = '{4'hF,  4'hF,  8'hE1};
    vecs[2] = '{4'hF,  4'd0,  8'h00};
    vecs[3] = '{4'd1,  4'hD,  8'h0D};
    vecs[4] = '{4'd0,  4'hF,  8'h00};
    vecs[5] = '{4'd8,  4'd8,  8'd64};
    vecs[6] = '{4'hA,  4'h5,  8'd50};
    vecs[7] = '{4'hE,  4'hB,  8'd154};

    reset = 1'b1; start = 1'b0; a = '0; b = '0;
    last_prod = 8'h00;
    #1;
    check("reset busy", {7'd0, busy}, 8'd0);
    check("reset done", {7'd0, done}, 8'd0);
    check("reset product", product, 8'h00);
    #12 reset = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) begin
      do_mul(vecs[i].a, vecs[i].b, vecs[i].p, $sformatf("vec%0d", i));
    end

    // Start during RUN is ignored.
    a = 4'd7; b = 4'd6; start = 1'b1;
    tick();                             // cycle S+1
    start = 1'b0; a = 4'd0; b = 4'd0;
    tick();                             // cycle S+2
    start = 1'b1; a = 4'd2; b = 4'd2;
    tick();                             // cycle S+3
    start = 1'b0;
    check("sb busy", {7'd0, busy}, 8'd1);
    tick();                             // cycle S+4
    check("sb busy4", {7'd0, busy}, 8'd1);
    check("sb hold", product, last_prod);
    tick();                             // cycle S+5
    check("sb done", {7'd0, done}, 8'd1);
    check("sb product", product, 8'd42);
    $display("start-while-busy 7 x 6 -> %0d", product);
    last_prod = 8'd42;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("sb no second", {7'd0, done | busy}, 8'd0);
    end

    // Back-to-back: new start in the DONE cycle.
    a = 4'd9; b = 4'd9; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    check("b2b first done", {7'd0, done}, 8'd1);
    check("b2b first", product, 8'd81);
    $display("b2b first 9 x 9 -> %0d", product);
    a = 4'd12; b = 4'd10; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("b2b busy", {7'd0, busy}, 8'd1);
      check("b2b hold 81", product, 8'd81);
      tick();
    end
    check("b2b second done", {7'd0, done}, 8'd1);
    check("b2b second", product, 8'd120);
    $display("b2b second 12 x 10 -> %0d", product);
    tick();

    // Asynchronous reset mid-RUN, mid-cycle.
    a = 4'd3; b = 4'd5; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    #3 reset = 1'b1;
    #1;
    check("arst busy", {7'd0, busy}, 8'd0);
    check("arst done", {7'd0, done}, 8'd0);
    check("arst product", product, 8'h00);
    $display("async reset mid-run: busy=%0d done=%0d product=%0d", busy, done, product);
    #2 reset = 1'b0;
    last_prod = 8'h00;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("arst no done", {7'd0, done | busy}, 8'd0);
    end

    // Exhaustive sweep with a bounded wait for done.
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        logic [7:0] exp;
        bit got;
        exp = 8'(ia * ib);
        a = 4'(ia); b = 4'(ib); start = 1'b1;
        tick();
        start = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
          tick();
          if (done) got = 1'b1;
        end
        if (!got) begin
          checks++; errors++;
          $display("FAIL sweep timeout %0d x %0d: done not seen, expected done=1", ia, ib);
        end else begin
          check($sformatf("sweep %0d x %0d", ia, ib), product, exp);
        end
        tick();
      end
    end
    $display("sweep of 256 pairs complete");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
